imem_fetch_ctrl: RTL and testbench

//  Sequences reads from the 64-bit synchronous instruction memory and delivers an aligned

---
 rtl/imem_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer between the 64-bit synchronous instruction memory and the
//   decode stage. Issues line reads, buffers the returned halfwords in an
//   8-entry queue, reassembles 32-bit instructions (including ones straddling
//   two lines) and presents one aligned instruction at a time to decode over a
//   valid/ready handshake. A redirect restarts the stream at a new PC.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   o_imem_addr    registered imem line address
//   i_imem_rdata   imem data for the address presented the previous cycle
//   i_redirect     one-cycle pulse: restart fetch at i_redirect_pc
//   i_redirect_pc  new byte PC (bit 0 ignored)
//   o_valid        o_instr/o_pc/o_is_rvc hold a complete instruction
//   i_ready        decode accepts the instruction this cycle
//   o_instr        instruction; compressed ones zero-extended {16'h0, hw}
//   o_pc           byte PC of o_instr
//   o_is_rvc       o_instr is a 16-bit compressed instruction
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int          DEPTH      = 2048,
   parameter int          ADDR_WIDTH = $clog2(DEPTH),
   parameter logic [63:0] RESET_PC   = 64'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic [63:0]           i_imem_rdata,
   input  logic                  i_redirect,
   input  logic [63:0]           i_redirect_pc,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [31:0]           o_instr,
   output logic [63:0]           o_pc,
   output logic                  o_is_rvc
);

   typedef enum logic [1:0] {S_IDLE, S_FIRST, S_STREAM} state_t;

   localparam logic [ADDR_WIDTH-1:0] LP_RST_LINE  = RESET_PC[ADDR_WIDTH+2:3];
   localparam logic [ADDR_WIDTH-1:0] LP_LAST_LINE = ADDR_WIDTH'(DEPTH - 1);

   state_t                r_state;
   logic [15:0]           r_q [8];
   logic [3:0]            r_count;
   logic                  r_pending;
   logic [1:0]            r_skip;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [63:0]           r_pc;

   logic                  w_is_rvc;
   logic                  w_valid;
   logic                  w_fire;
   logic                  w_issue;
   logic                  w_append;
   logic [1:0]            w_pop;
   logic [1:0]            w_skip_eff;
   logic [2:0]            w_n_app;
   logic [3:0]            w_base;
   logic [3:0]            w_count_next;
   logic [15:0]           w_q_next [8];

   // Head decode is purely from registered queue state.
   assign w_is_rvc = (r_q[0][1:0] != 2'b11);
   assign w_valid  = (r_count != 4'd0) && (w_is_rvc || (r_count >= 4'd2));

   // A redirect in the same cycle kills the handshake and any append.
   assign w_fire   = w_valid && i_ready && !i_redirect;
   assign w_append = r_pending && !i_redirect;

   // Pop is ignored when deciding to issue, so the queue can never overflow:
   // a read is only sent when the queue plus in-flight data leaves room for 4.
   assign w_issue  = !i_redirect &&
                     (({1'b0, r_count} + (r_pending ? 5'd4 : 5'd0)) <= 5'd4);

   assign w_pop      = w_fire ? (w_is_rvc ? 2'd1 : 2'd2) : 2'd0;
   // Only the first line of a stream starts mid-line.
   assign w_skip_eff = (r_state == S_FIRST) ? r_skip : 2'd0;
   assign w_n_app    = w_append ? (3'd4 - {1'b0, w_skip_eff}) : 3'd0;
   assign w_base     = r_count - {2'b00, w_pop};
   assign w_count_next = w_base + {1'b0, w_n_app};

   // Queue next state: shift out popped entries, then drop appended halfwords
   // in behind the surviving ones. Slots above the new count hold don't-care data.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_q_next[i] = r_q[3'(i) + {1'b0, w_pop}];
         for (int k = 0; k < 4; k++) begin
            if (w_append && (k >= int'(w_skip_eff)) &&
                (i == int'(w_base) + k - int'(w_skip_eff))) begin
               w_q_next[i] = i_imem_rdata[16*k +: 16];
            end
         end
      end
   end

   // Queue payload carries no reset; r_count alone says which slots are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         r_q[i] <= w_q_next[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_count   <= 4'd0;
         r_pending <= 1'b0;
         r_skip    <= RESET_PC[2:1];
         r_addr    <= LP_RST_LINE;
         r_pc      <= RESET_PC;
      end else if (i_redirect) begin
         // Flush everything; a response arriving next cycle belongs to the old
         // stream and is dropped because pending is cleared here.
         r_state   <= S_FIRST;
         r_count   <= 4'd0;
         r_pending <= 1'b0;
         r_skip    <= i_redirect_pc[2:1];
         r_addr    <= i_redirect_pc[ADDR_WIDTH+2:3];
         r_pc      <= {i_redirect_pc[63:1], 1'b0};
      end else begin
         r_pending <= w_issue;
         r_count   <= w_count_next;
         if (w_issue) begin
            r_addr <= (r_addr == LP_LAST_LINE) ? '0 : r_addr + ADDR_WIDTH'(1);
         end
         if (w_fire) begin
            r_pc <= r_pc + (w_is_rvc ? 64'd2 : 64'd4);
         end
         case (r_state)
            S_IDLE:   r_state <= S_FIRST;
            S_FIRST:  if (r_pending) r_state <= S_STREAM;
            S_STREAM: r_state <= S_STREAM;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign o_imem_addr = r_addr;
   assign o_valid     = w_valid;
   assign o_is_rvc    = w_is_rvc;
   assign o_instr     = w_is_rvc ? {16'h0000, r_q[0]} : {r_q[1], r_q[0]};
   assign o_pc        = r_pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Bench for imem_fetch_ctrl. A synchronous memory model feeds the DUT; a
//   reference model walks the program image by PC (halfword lookup, RVC vs
//   32-bit by the low two bits) and checks every accepted instruction.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   localparam int          DEPTH    = 2048;
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [63:0] RESET_PC = 64'h0;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] o_imem_addr;
   logic [63:0]   i_imem_rdata;
   logic          i_redirect;
   logic [63:0]   i_redirect_pc;
   logic          o_valid;
   logic          i_ready;
   logic [31:0]   o_instr;
   logic [63:0]   o_pc;
   logic          o_is_rvc;

   logic [63:0]   mem [DEPTH];

   int            n_chk  = 0;
   int            n_pass = 0;
   int            n_hs   = 0;
   logic [63:0]   m_pc;
   logic          h_vld;
   logic [31:0]   h_instr;
   logic [63:0]   h_pc;
   logic          h_rvc;

   imem_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .o_imem_addr  (o_imem_addr),
      .i_imem_rdata (i_imem_rdata),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_is_rvc     (o_is_rvc)
   );

   always #5 clk = ~clk;

   // One-cycle-latency synchronous memory.
   always @(posedge clk) i_imem_rdata <= mem[o_imem_addr];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] hw_at(input logic [63:0] a);
      logic [63:0] line;
      line = mem[int'((a >> 3) % 64'(DEPTH))];
      return line[16*int'(a[2:1]) +: 16];
   endfunction

   // Drive one cycle's inputs (called at negedge), score it, advance to next negedge.
   task automatic cyc(input logic rdy, input logic redir, input logic [63:0] rpc);
      logic [15:0] h0;
      logic        e_rvc;
      logic [31:0] e_instr;
      i_ready = rdy; i_redirect = redir; i_redirect_pc = rpc;
      if (h_vld) begin
         chk("hold_valid", 64'(o_valid), 64'd1);
         chk("hold_instr", 64'(o_instr), 64'(h_instr));
         chk("hold_pc", o_pc, h_pc);
         chk("hold_rvc", 64'(o_is_rvc), 64'(h_rvc));
      end
      h_vld = 1'b0;
      if (rst) begin
         m_pc = RESET_PC;
      end else if (redir) begin
         m_pc = {rpc[63:1], 1'b0};
      end else if (o_valid && rdy) begin
         h0 = hw_at(m_pc);
         e_rvc = (h0[1:0] != 2'b11);
         e_instr = e_rvc ? {16'h0, h0} : {hw_at(m_pc + 64'd2), h0};
         chk("pc", o_pc, m_pc);
         chk("instr", 64'(o_instr), 64'(e_instr));
         chk("is_rvc", 64'(o_is_rvc), 64'(e_rvc));
         m_pc = m_pc + (e_rvc ? 64'd2 : 64'd4);
         n_hs++;
      end else if (o_valid) begin
         h_vld = 1'b1; h_instr = o_instr; h_pc = o_pc; h_rvc = o_is_rvc;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; i_redirect = 1'b0; i_ready = 1'b0; i_redirect_pc = '0; h_vld = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_pc", o_pc, RESET_PC);
      chk("rst_addr", 64'(o_imem_addr), 64'(RESET_PC[AW+2:3]));
      repeat (2) begin @(posedge clk); @(negedge clk); end
      m_pc = RESET_PC;
      rst = 1'b0;
   endtask

   // Cycles (counting the first cycle after release as 1) until o_valid.
   task automatic first_valid(input logic rdy, output int n);
      n = 1;
      while (!o_valid && n < 20) begin cyc(rdy, 1'b0, 64'h0); n++; end
   endtask

   initial begin
      int n;
      logic [31:0] seen;
      for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
      rst = 1'b1; i_redirect = 1'b0; i_ready = 1'b0; i_redirect_pc = '0; h_vld = 1'b0;
      @(negedge clk);

      // Four compressed instructions in line 0.
      mem[0] = {16'h468d, 16'h4609, 16'h4585, 16'h4501};
      do_reset();
      first_valid(1'b1, n);
      chk("rvc_first_valid_cycle", 64'(n), 64'd3);
      chk("rvc_first_is_rvc", 64'(o_is_rvc), 64'd1);
      repeat (12) cyc(1'b1, 1'b0, 64'h0);

      // Two 32-bit instructions in line 0.
      mem[0] = {32'h00a00113, 32'h00500093};
      do_reset();
      first_valid(1'b1, n);
      chk("w32_first_valid_cycle", 64'(n), 64'd3);
      chk("w32_first_instr", 64'(o_instr), 64'h00500093);
      repeat (12) cyc(1'b1, 1'b0, 64'h0);

      // 32-bit instruction at pc 6 straddling into line 1.
      mem[0] = {16'h0193, 16'h4609, 16'h4585, 16'h4501};
      mem[1] = {48'h0001_0001_0001, 16'h00b0};
      do_reset();
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         if (o_valid && o_pc == 64'd6) seen = o_instr;
         cyc(1'b1, 1'b0, 64'h0);
      end
      chk("straddle_instr", 64'(seen), 64'h00b00193);

      // Redirect to 0x1A with a read in flight.
      do_reset();
      cyc(1'b0, 1'b0, 64'h0);
      cyc(1'b0, 1'b0, 64'h0);
      cyc(1'b1, 1'b1, 64'h1A);
      chk("redir_addr", 64'(o_imem_addr), 64'd3);
      chk("redir_t1_valid", 64'(o_valid), 64'd0);
      cyc(1'b1, 1'b0, 64'h0);
      chk("redir_t2_valid", 64'(o_valid), 64'd0);
      cyc(1'b1, 1'b0, 64'h0);
      chk("redir_t3_valid", 64'(o_valid), 64'd1);
      chk("redir_t3_pc", o_pc, 64'h1A);
      repeat (12) cyc(1'b1, 1'b0, 64'h0);

      // Decode stalled for 20 cycles: two lines fill the queue, then no reads.
      do_reset();
      repeat (20) cyc(1'b0, 1'b0, 64'h0);
      chk("stall_addr", 64'(o_imem_addr), 64'(RESET_PC[AW+2:3]) + 64'd2);
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_pc", o_pc, RESET_PC);
      repeat (12) cyc(1'b1, 1'b0, 64'h0);

      // Stream across the last line; then reset mid-stream.
      cyc(1'b1, 1'b1, 64'((DEPTH - 1) * 8));
      chk("wrap_last_addr", 64'(o_imem_addr), 64'(DEPTH - 1));
      cyc(1'b1, 1'b0, 64'h0);
      chk("wrap_zero_addr", 64'(o_imem_addr), 64'd0);
      repeat (20) cyc(1'b1, 1'b0, 64'h0);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 64'h0);
      chk("midrst_valid", 64'(o_valid), 64'd0);
      chk("midrst_pc", o_pc, RESET_PC);
      chk("midrst_addr", 64'(o_imem_addr), 64'(RESET_PC[AW+2:3]));
      rst = 1'b0;
      m_pc = RESET_PC;
      first_valid(1'b1, n);
      chk("midrst_restart_cycle", 64'(n), 64'd3);

      // Random ready and redirects across a random image.
      n_hs = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        rd;
         logic [63:0] rp;
         rd = ($urandom_range(0, 99) < 3);
         rp = 64'({$urandom_range(0, 32767), 1'b0});
         cyc(($urandom_range(0, 3) != 0), rd, rp);
      end
      chk("random_progress", 64'(n_hs > 800), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
